// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared types and constants for the sysid boot checker: FSM states,
// default expected sysid contents and the sysid slave word addresses.
package first_nios2_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [31:0] DEF_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1457818839;

  localparam logic SYSID_ADDR_ID        = 1'b0;
  localparam logic SYSID_ADDR_TIMESTAMP = 1'b1;

endpackage

// File: rtl/first_nios2_system_sysid_rd_timer.sv
// Read-strobe hold timer shared by both sysid word reads: counts READ_LATENCY
// cycles while run is high and flags the capture cycle with last.
module first_nios2_system_sysid_rd_timer #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic last
);

  localparam logic [2:0] LOAD = 3'(READ_LATENCY);

  logic [2:0] cnt_q, cnt_d;

  assign last = run && (cnt_q == 3'd1);

  // Reload on the capture cycle so a back-to-back second word starts fresh.
  always_comb begin
    cnt_d = cnt_q - 3'd1;
    if (!run || last) cnt_d = LOAD;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= LOAD;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time sysid verifier: reads sysid word 0 (and word 1 when
// SYSID_CHECKER_TIMESTAMP_CHECK_EN is defined), compares, retries, reports.
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [2:0]  retry_count
);

  localparam logic [2:0] MAX_RETRY = 3'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic        rd_last, id_match, ts_match, launch;
  logic        m_address_q, m_address_d, m_read_q, m_read_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
  logic [2:0]  retry_q, retry_d;

  first_nios2_system_sysid_rd_timer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .run    ((state_q == ST_RD_ID) || (state_q == ST_RD_TS)),
    .last   (rd_last)
  );

  assign id_match = (cap_id_q == EXPECTED_ID);
`ifdef SYSID_CHECKER_TIMESTAMP_CHECK_EN
  assign ts_match = (cap_ts_q == EXPECTED_TIMESTAMP);
`else
  assign ts_match = 1'b1;
`endif

  assign launch = ((state_q == ST_IDLE) && (auto_q || start)) ||
                  ((state_q == ST_DONE) && start);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    case (state_q)
      ST_IDLE: if (auto_q || start) begin
        state_d = ST_RD_ID;
        auto_d  = 1'b0;
      end
`ifdef SYSID_CHECKER_TIMESTAMP_CHECK_EN
      ST_RD_ID: if (rd_last) state_d = ST_RD_TS;
      ST_RD_TS: if (rd_last) state_d = ST_CHECK;
`else
      ST_RD_ID: if (rd_last) state_d = ST_CHECK;
`endif
      ST_CHECK: begin
        if (id_match && ts_match)   state_d = ST_DONE;
        else if (retry_q < MAX_RETRY) state_d = ST_RD_ID;
        else                        state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_RD_ID;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus/status outputs are registered from the next state so they line up
  // with the state register.
  always_comb begin
    m_read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
    m_address_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TIMESTAMP : SYSID_ADDR_ID;
    busy_d      = m_read_d || (state_d == ST_CHECK);
    done_d      = (state_d == ST_DONE);
    pass_d      = pass_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    retry_d     = retry_q;
    cap_id_d    = cap_id_q;
    cap_ts_d    = cap_ts_q;
    if (launch) begin
      pass_d  = 1'b0;
      id_ok_d = 1'b0;
      ts_ok_d = 1'b0;
      retry_d = 3'd0;
    end
    if (state_q == ST_RD_ID && rd_last) cap_id_d = m_readdata;
`ifdef SYSID_CHECKER_TIMESTAMP_CHECK_EN
    if (state_q == ST_RD_TS && rd_last) cap_ts_d = m_readdata;
`endif
    if (state_q == ST_CHECK) begin
      id_ok_d = id_match;
      ts_ok_d = ts_match;
      if (id_match && ts_match)      pass_d  = 1'b1;
      else if (retry_q < MAX_RETRY)  retry_d = retry_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_read_q    <= 1'b0;
      m_address_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      retry_q     <= 3'd0;
      cap_id_q    <= 32'd0;
      cap_ts_q    <= 32'd0;
    end else begin
      m_read_q    <= m_read_d;
      m_address_q <= m_address_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      retry_q     <= retry_d;
      cap_id_q    <= cap_id_d;
      cap_ts_q    <= cap_ts_d;
    end
  end

  assign m_read      = m_read_q;
  assign m_address   = m_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign retry_count = retry_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench: DUT a (READ_LATENCY=1) for pass/retry/start handling,
// DUT b (READ_LATENCY=3) for mid-sequence reset and auto re-run.
module tb_first_nios2_system_sysid_checker;

`ifdef SYSID_CHECKER_TIMESTAMP_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [31:0] GOOD_TS = 32'd1457818839;
  localparam logic [31:0] EXP_TS  = TS_EN ? GOOD_TS : 32'd0;
  localparam int ATT_A = TS_EN ? 3 : 2;   // cycles per attempt, RL=1
  localparam int ATT_B = TS_EN ? 7 : 4;   // cycles per attempt, RL=3

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic start;
  logic a_rst, a_m_address, a_m_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok;
  logic [31:0] a_rdata, a_cap_id, a_cap_ts, a_id_val, corrupt;
  logic [2:0] a_retry;
  logic b_rst, b_m_address, b_m_read, b_busy, b_done, b_pass, b_id_ok, b_ts_ok;
  logic [31:0] b_rdata, b_cap_id, b_cap_ts;
  logic [2:0] b_retry;

  int total = 0, bad = 0;
  int a_rd_cnt = 0, a_id_rd = 0, bad_until = 0;
  logic a_addr_hi = 1'b0;

  first_nios2_system_sysid_checker #(.READ_LATENCY(1), .MAX_RETRIES(3)) dut_a (
    .clock(clock), .reset_n(a_rst), .start(start),
    .m_address(a_m_address), .m_read(a_m_read), .m_readdata(a_rdata),
    .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .captured_id(a_cap_id), .captured_ts(a_cap_ts), .retry_count(a_retry));

  first_nios2_system_sysid_checker #(.READ_LATENCY(3), .MAX_RETRIES(3)) dut_b (
    .clock(clock), .reset_n(b_rst), .start(start),
    .m_address(b_m_address), .m_read(b_m_read), .m_readdata(b_rdata),
    .busy(b_busy), .done(b_done), .pass(b_pass), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .captured_id(b_cap_id), .captured_ts(b_cap_ts), .retry_count(b_retry));

  // Combinational sysid slave models; a can corrupt the last-checked word
  // for a bounded number of attempts.
  always_comb begin
    corrupt = (a_rd_cnt < bad_until) ? 32'h1 : 32'h0;
    if (a_m_address) a_rdata = GOOD_TS ^ (TS_EN ? corrupt : 32'h0);
    else             a_rdata = a_id_val ^ (TS_EN ? 32'h0 : corrupt);
    b_rdata = b_m_address ? GOOD_TS : 32'd0;
  end

  always @(posedge clock) begin
    if (a_m_read && (a_m_address == TS_EN)) a_rd_cnt <= a_rd_cnt + 1;
    if (a_m_read && !a_m_address)           a_id_rd  <= a_id_rd + 1;
    if (a_m_address)                        a_addr_hi <= 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges until done rises; capped so a stuck DUT shows up as a latency miss.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((sel ? b_done : a_done) !== 1'b1) && n < 300);
  endtask

  int n, snap;

  initial begin
    start = 0; a_rst = 0; b_rst = 0; a_id_val = 32'd0;
    #12;
    chk("rst_m_read", a_m_read, 0);
    chk("rst_m_addr", a_m_address, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_ok", {a_id_ok, a_ts_ok}, 0);
    chk("rst_retry", a_retry, 0);
    chk("rst_cap", a_cap_id | a_cap_ts, 0);

    // Auto-start after reset release, all words good
    a_rst = 1;
    tick();
    chk("auto_m_read", a_m_read, 1);
    chk("auto_busy", a_busy, 1);
    wait_done(0, n);
    chk("auto_lat", n + 1, ATT_A + 1);
    chk("auto_pass", a_pass, 1);
    chk("auto_retry", a_retry, 0);
    chk("auto_ok", {a_id_ok, a_ts_ok}, 2'b11);
    chk("auto_cap_ts", a_cap_ts, EXP_TS);
    chk("auto_idle_bus", {a_busy, a_m_read, a_m_address}, 0);

    // Persistent bad ID: all retries consumed
    a_id_val = 32'h5;
    snap = a_id_rd;
    start = 1; tick(); start = 0;
    wait_done(0, n);
    chk("badid_done", a_done, 1);
    chk("badid_pass", a_pass, 0);
    chk("badid_id_ok", a_id_ok, 0);
    chk("badid_ts_ok", a_ts_ok, 1);
    chk("badid_retry", a_retry, 3);
    chk("badid_cap", a_cap_id, 32'h5);
    chk("badid_attempts", a_id_rd - snap, 4);
    a_id_val = 32'd0;

    // First attempt corrupt, from reset: one retry then pass
    bad_until = a_rd_cnt + 1;
    a_rst = 0;
    #1;
    chk("rst2_clear", {a_done, a_pass, a_retry}, 0);
    a_rst = 1;
    wait_done(0, n);
    chk("retry1_lat", n, 2 * ATT_A + 1);
    chk("retry1_cnt", a_retry, 1);
    chk("retry1_pass", a_pass, 1);

    // start while busy is dropped
    snap = a_id_rd;
    start = 1; tick(); start = 0;
    tick();
    start = 1; tick(); start = 0;
    wait_done(0, n);
    repeat (3) tick();
    chk("busystart_single", a_id_rd - snap, 1);
    chk("busystart_held", {a_done, a_busy}, 2'b10);

    // start in DONE: done drops next cycle, rerun passes
    start = 1; tick(); start = 0;
    chk("rerun_done_drop", a_done, 0);
    chk("rerun_busy", a_busy, 1);
    wait_done(0, n);
    chk("rerun_pass", a_pass, 1);
    chk("rerun_retry", a_retry, 0);
    chk("addr_hi_seen", a_addr_hi, TS_EN);

    // DUT b: READ_LATENCY=3, reset mid-sequence
    b_rst = 1;
    wait_done(1, n);
    chk("b_auto_lat", n, ATT_B + 1);
    start = 1; tick(); start = 0;
    repeat (TS_EN ? 3 : 1) tick();
    chk("b_mid_addr", b_m_address, TS_EN);
    chk("b_mid_read", b_m_read, 1);
    b_rst = 0;
    #1;
    chk("b_abort", {b_m_read, b_m_address, b_busy, b_done, b_pass}, 0);
    chk("b_abort_cap", b_cap_ts, 0);
    b_rst = 1;
    wait_done(1, n);
    chk("b_rerun_lat", n, ATT_B + 1);
    chk("b_rerun_pass", b_pass, 1);
    chk("b_rerun_stat", {b_retry, b_id_ok, b_ts_ok}, 5'b00011);
    chk("b_rerun_cap", b_cap_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/first_nios2_system_sysid_checker.md
# first_nios2_system_sysid_checker

Boot-time system-ID verifier for the Nios II system. After reset, or on request, it issues Avalon-MM reads to the sysid control slave: word 0 is the system ID and word 1 is the timestamp. It compares both words against build-time expected values, retries on mismatch, and drives pass/fail status for the reset sequencer and the status LEDs.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, expected value of sysid word 0
- EXPECTED_TIMESTAMP, 32'd1457818839, expected value of sysid word 1
- READ_LATENCY, 1, cycles `m_read` is held per word (legal range 1..4); data is captured on the last cycle
- MAX_RETRIES, 3, extra attempts after the first failed check (legal range 0..7)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to re-run the check; ignored while `busy`
- m_address  out  1  sysid word select
- m_read  out  1  read strobe
- m_readdata  in  32  sysid read data
- busy  out  1  check sequence in progress
- done  out  1  sequence finished; level, held until next start
- pass  out  1  both words matched on the final attempt
- id_ok  out  1  word 0 matched on the latest attempt
- ts_ok  out  1  word 1 matched on the latest attempt
- captured_id  out  32  last word-0 value read
- captured_ts  out  32  last word-1 value read
- retry_count  out  3  number of retries used

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- Reset values: state = IDLE; all outputs are 0; the auto-start flag is set.
- IDLE: if the auto-start flag is set or `start` = 1, go to RD_ID, clear the auto-start flag, and clear `done`, `pass`, `id_ok`, `ts_ok` and `retry_count`.
- RD_ID: `m_read` = 1, `m_address` = 0 for READ_LATENCY cycles. On the last cycle, capture `m_readdata` into `captured_id`, then go to RD_TS.
- RD_TS: `m_read` = 1, `m_address` = 1 for READ_LATENCY cycles. On the last cycle, capture `m_readdata` into `captured_ts`, then go to CHECK.
- CHECK: set `id_ok` = (captured_id == EXPECTED_ID) and `ts_ok` = (captured_ts == EXPECTED_TIMESTAMP).
  - Both match: go to DONE with `pass` = 1.
  - Mismatch with `retry_count` < MAX_RETRIES: increment `retry_count` and go to RD_ID. `captured_*` values are overwritten on the retry.
  - Mismatch with `retry_count` = MAX_RETRIES: go to DONE with `pass` = 0.
- DONE: `done` = 1. `start` = 1 re-enters RD_ID, applying the same clears as IDLE.
- `busy` = 1 in RD_ID, RD_TS and CHECK.
- `m_read` = 0 in every other state. `m_address` = 0 when `m_read` = 0.
- `start` pulses arriving in RD_ID, RD_TS or CHECK are dropped, not queued.
- Reset asserted mid-sequence aborts immediately to reset values. The sequence auto-runs again after release.

## Timing
- All outputs are registered.
- With `start` sampled at edge E0: `m_read` is high during cycles E0+1 through E0+2·READ_LATENCY. CHECK occupies the next cycle. `done`, `pass`, `id_ok` and `ts_ok` become valid after edge E0+2·READ_LATENCY+2.
- Each retry adds 2·READ_LATENCY+1 cycles.
- Auto-start: the first RD_ID cycle follows the first rising edge after reset_n deasserts.
- `m_readdata` must be stable on the capture cycle. The sysid slave is combinational, so READ_LATENCY = 1 is sufficient.

## Configuration
- Macro: SYSID_CHECKER_TIMESTAMP_CHECK_EN.
- Defined: full sequence as described above.
- Undefined:
  - RD_TS is skipped; RD_ID goes directly to CHECK.
  - `captured_ts` stays 0 and `ts_ok` is forced to 1.
  - Latency becomes READ_LATENCY+2 cycles per attempt.

## Structure
- Shared package `first_nios2_system_sysid_pkg` holds:
  - the state enum
  - the default expected ID and timestamp constants
  - the sysid word-address constants (ID = 0, TIMESTAMP = 1)
- Sub-module `first_nios2_system_sysid_rd_timer`: a down-counter loaded with READ_LATENCY that pulses `last` on the capture cycle. It is shared by RD_ID and RD_TS.

## Test plan
- Reset release, slave returns ID 0 and timestamp 1457818839, READ_LATENCY = 1 → `done` = 1 and `pass` = 1 after 4 cycles, `retry_count` = 0.
- Slave returns ID 0x5 on every read, MAX_RETRIES = 3 → 4 attempts, `pass` = 0, `id_ok` = 0, `ts_ok` = 1, `retry_count` = 3, `captured_id` = 0x5.
- Bad timestamp on the first attempt only → `retry_count` = 1, `pass` = 1, `done` after 7 cycles.
- `start` pulsed during RD_TS → ignored, single sequence. `start` pulsed in DONE → `done` drops next cycle, sequence reruns and `pass` = 1 again.
- reset_n asserted during RD_TS with READ_LATENCY = 3 → all outputs 0 immediately; after release the sequence auto-runs and `done` appears after 8 cycles.
- Macro undefined → `m_address` is never 1, `captured_ts` = 0, `done` after 3 cycles with READ_LATENCY = 1.
